// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider controller:
// controller states and the default counter width / reset half-period.
package clkdiv_pkg;

  // Default width of the half-period value.
  localparam int CLKDIV_CNT_W    = 16;
  // Half-period loaded at reset: 163 gives a 326-cycle period from clk50.
  localparam int CLKDIV_DEF_HALF = 163;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/clkdiv_if.sv
// Configuration handshake for the clock divider: a new half-period is
// offered with cfg_valid/cfg_half and taken when cfg_ready is high.
// cfg_err flags a rejected zero half-period.
interface clkdiv_if
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CLKDIV_CNT_W
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_err;

  // Side that offers new configurations.
  modport master (
    output cfg_valid,
    output cfg_half,
    input  cfg_ready,
    input  cfg_err
  );

  // Side that accepts them (the controller).
  modport slave (
    input  cfg_valid,
    input  cfg_half,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clkdiv_core.sv
// Period counter and compare logic of the clock divider.
// While run_en is high the counter advances every clk50 edge; clkout rises
// when the counter reaches half-1 and falls (with counter wrap) at 2*half-1,
// which is the period boundary. half_reg only changes through the load port.
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int CNT_W    = CLKDIV_CNT_W,
  parameter int DEF_HALF = CLKDIV_DEF_HALF
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             run_en,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_half,
  output logic             rise_evt,
  output logic             bound_evt,
  output logic             clkout
);

  // The counter spans a whole period (up to 2*half-1), so it carries one
  // extra bit; half-periods above 2^(CNT_W-1) still reach the boundary.
  logic [CNT_W:0]   cnt_reg;
  logic [CNT_W-1:0] half_reg;
  logic [CNT_W-1:0] half_m1;
  logic [CNT_W:0]   period_m1;
  logic             clkout_reg;

  assign half_m1   = half_reg - CNT_W'(1);
  assign period_m1 = {half_reg, 1'b0} - (CNT_W+1)'(1);

  // Compare events are only meaningful while the divider is running.
  assign rise_evt  = run_en && (cnt_reg == {1'b0, half_m1});
  assign bound_evt = run_en && (cnt_reg == period_m1);
  assign clkout    = clkout_reg;

  // Counter, divided clock and half-period register.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      half_reg   <= CNT_W'(DEF_HALF);
      clkout_reg <= 1'b0;
    end else begin
      if (run_en) begin
        if (bound_evt) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + (CNT_W+1)'(1);
        end
      end
      if (bound_evt) begin
        clkout_reg <= 1'b0;
      end else if (rise_evt) begin
        clkout_reg <= 1'b1;
      end
      if (load_en) begin
        half_reg <= load_half;
      end
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run-time controller for the programmable clock divider.
// Starts/stops the divided clock on period boundaries and takes new
// half-periods over a valid/ready handshake. A value accepted while running
// is parked in a pending register and applied at the next period boundary,
// so the current period always completes with the old half-period.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_W    = CLKDIV_CNT_W,
  parameter int DEF_HALF = CLKDIV_DEF_HALF
) (
  input  logic     clk50,
  input  logic     rst,
  input  logic     start,
  input  logic     stop,
  clkdiv_if.slave  cfg,
  output logic     clkout,
  output logic     tick,
  output logic     busy
);

  state_t           state_reg;
  logic             busy_reg;
  logic             tick_reg;
  logic             cfg_ready_reg;
  logic             cfg_err_reg;
  logic             pend_valid_reg;
  logic [CNT_W-1:0] pend_half_reg;

  logic             run_en;
  logic             accept;
  logic             accept_zero;
  logic             accept_ok;
  logic             pend_apply;
  logic             load_en;
  logic [CNT_W-1:0] load_half;
  logic             rise_evt;
  logic             bound_evt;

  assign run_en      = (state_reg != IDLE);
  assign accept      = cfg.cfg_valid && cfg_ready_reg;
  assign accept_zero = accept && (cfg.cfg_half == '0);
  assign accept_ok   = accept && (cfg.cfg_half != '0);

  // A pending value is applied at a period boundary. An offer taken on the
  // very edge where DRAIN finishes lands while already IDLE, so IDLE also
  // flushes a pending value (one cycle later, before any new run starts).
  assign pend_apply  = pend_valid_reg && (bound_evt || state_reg == IDLE);
  assign load_en     = pend_apply || (accept_ok && state_reg == IDLE);
  assign load_half   = pend_valid_reg ? pend_half_reg : cfg.cfg_half;

  clkdiv_core #(
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF_HALF)
  ) u_core (
    .clk50     (clk50),
    .rst       (rst),
    .run_en    (run_en),
    .load_en   (load_en),
    .load_half (load_half),
    .rise_evt  (rise_evt),
    .bound_evt (bound_evt),
    .clkout    (clkout)
  );

  assign tick          = tick_reg;
  assign busy          = busy_reg;
  assign cfg.cfg_ready = cfg_ready_reg;
  assign cfg.cfg_err   = cfg_err_reg;

  // Run/stop FSM, config handshake and pending register.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      tick_reg       <= 1'b0;
      cfg_ready_reg  <= 1'b1;
      cfg_err_reg    <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_half_reg  <= '0;
    end else begin
      tick_reg    <= rise_evt;
      cfg_err_reg <= accept_zero;

      // cfg_ready is only high with nothing pending, so apply and accept
      // never collide.
      if (pend_apply) begin
        pend_valid_reg <= 1'b0;
        cfg_ready_reg  <= 1'b1;
      end
      if (accept_ok && state_reg != IDLE) begin
        pend_half_reg  <= cfg.cfg_half;
        pend_valid_reg <= 1'b1;
        cfg_ready_reg  <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (start) begin
            state_reg <= RUN;
          end else if (bound_evt) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: a table of start/config vectors with
// hand-computed edge positions, plus sequences for mid-run config,
// illegal config, stop/restart during DRAIN and asynchronous reset.
// Edge numbering: the edge that samples start is E0; e_idx = k after Ek.
module tb_clkdiv_ctrl;
  import clkdiv_pkg::*;

  localparam int CW = 16;

  logic clk50 = 1'b0;
  logic rst;
  logic start;
  logic stop;
  logic clkout;
  logic tick;
  logic busy;

  clkdiv_if #(.CNT_W(CW)) cfg_if ();

  clkdiv_ctrl #(
    .CNT_W    (CW),
    .DEF_HALF (163)
  ) dut (
    .clk50  (clk50),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .cfg    (cfg_if.slave),
    .clkout (clkout),
    .tick   (tick),
    .busy   (busy)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    int cfg;     // half-period offered with start (0 = no offer)
    int rise1;   // edge of first clkout rise
    int fall1;   // edge of first clkout fall (period boundary)
    int rise2;   // edge of second rise
  } vec_t;

  vec_t vecs[6];

  int   tests = 0;
  int   fails = 0;
  int   e_idx = 0;
  int   rise_a[16];
  int   fall_a[16];
  int   rise_n = 0;
  int   fall_n = 0;
  int   tick_bad = 0;
  logic prev_clk = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int rise_at(input int i);
    return (i < rise_n && i < 16) ? rise_a[i] : -1;
  endfunction

  function automatic int fall_at(input int i);
    return (i < fall_n && i < 16) ? fall_a[i] : -1;
  endfunction

  // Advance one clk50 edge, sample 1 time unit later and log edges.
  task automatic step();
    @(posedge clk50);
    #1;
    e_idx++;
    if (clkout && !prev_clk) begin
      if (rise_n < 16) rise_a[rise_n] = e_idx;
      rise_n++;
    end
    if (!clkout && prev_clk) begin
      if (fall_n < 16) fall_a[fall_n] = e_idx;
      fall_n++;
    end
    if (tick !== (clkout && !prev_clk)) tick_bad++;
    prev_clk = clkout;
  endtask

  task automatic clear_trace();
    e_idx    = 0;
    rise_n   = 0;
    fall_n   = 0;
    tick_bad = 0;
    prev_clk = clkout;
  endtask

  task automatic run_to(input int e);
    while (e_idx < e) step();
  endtask

  task automatic offer(input int h);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = CW'(h);
  endtask

  // Start edge E0, optionally with a config offer in the same cycle.
  task automatic kick(input int h);
    if (h != 0) offer(h);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    clear_trace();
  endtask

  // Request stop and wait (bounded) for the drain to reach IDLE.
  task automatic finish_run(input string name);
    int n;
    n = 0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk({name, "_idle_busy"}, int'(busy), 0);
    chk({name, "_idle_clkout"}, int'(clkout), 0);
  endtask

  initial begin
    int ready_ret;
    int busy_low;

    vecs[0] = '{0,   163, 326, 489};
    vecs[1] = '{4,   4,   8,   12};
    vecs[2] = '{1,   1,   2,   3};
    vecs[3] = '{2,   2,   4,   6};
    vecs[4] = '{0,   2,   4,   6};
    vecs[5] = '{100, 100, 200, 300};

    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_half  = '0;
    #35;
    chk("reset_clkout", int'(clkout), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cfg_ready", int'(cfg_if.cfg_ready), 1);
    chk("reset_cfg_err", int'(cfg_if.cfg_err), 0);
    rst = 1'b0;
    step();
    step();

    // Table: start (with optional config) and measure the first periods.
    for (int i = 0; i < 6; i++) begin
      kick(vecs[i].cfg);
      chk("vec_busy_after_start", int'(busy), 1);
      run_to(vecs[i].rise2 + 1);
      chk("vec_rise1", rise_at(0), vecs[i].rise1);
      chk("vec_fall1", fall_at(0), vecs[i].fall1);
      chk("vec_rise2", rise_at(1), vecs[i].rise2);
      chk("vec_rise_count", rise_n, 2);
      chk("vec_tick_align", tick_bad, 0);
      $display("[TB] vec %0d cfg=%0d rise1=%0d fall1=%0d rise2=%0d", i,
               vecs[i].cfg, rise_at(0), fall_at(0), rise_at(1));
      finish_run("vec");
    end

    // Mid-run config: offer 10 at cnt=50 of a 163 run.
    kick(163);
    run_to(50);
    offer(10);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("midcfg_ready_low", int'(cfg_if.cfg_ready), 0);
    ready_ret = -1;
    while (e_idx < 360) begin
      step();
      if (ready_ret < 0 && cfg_if.cfg_ready) ready_ret = e_idx;
    end
    chk("midcfg_ready_return", ready_ret, 326);
    chk("midcfg_rise_old", rise_at(0), 163);
    chk("midcfg_boundary", fall_at(0), 326);
    chk("midcfg_rise_new", rise_at(1), 336);
    chk("midcfg_fall_new", fall_at(1), 346);
    chk("midcfg_rise_new2", rise_at(2), 356);
    chk("midcfg_tick_align", tick_bad, 0);
    $display("[TB] midcfg ready_return=%0d rises=%0d,%0d,%0d", ready_ret,
             rise_at(0), rise_at(1), rise_at(2));
    finish_run("midcfg");

    // Illegal zero config in IDLE, then in RUN (half is now 10).
    offer(0);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("zero_idle_err", int'(cfg_if.cfg_err), 1);
    chk("zero_idle_ready", int'(cfg_if.cfg_ready), 1);
    step();
    chk("zero_idle_err_clear", int'(cfg_if.cfg_err), 0);
    kick(0);
    run_to(25);
    offer(0);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("zero_run_err", int'(cfg_if.cfg_err), 1);
    chk("zero_run_ready", int'(cfg_if.cfg_ready), 1);
    step();
    chk("zero_run_err_clear", int'(cfg_if.cfg_err), 0);
    run_to(51);
    chk("zero_run_rise1", rise_at(0), 10);
    chk("zero_run_rise3", rise_at(2), 50);
    $display("[TB] zero-config rises=%0d,%0d,%0d", rise_at(0), rise_at(1), rise_at(2));
    finish_run("zero");

    // Stop during the high phase: output finishes the period, then IDLE.
    kick(0);
    while (e_idx < 19) begin
      stop = (e_idx == 12);
      step();
    end
    stop = 1'b0;
    chk("stop_high_clkout", int'(clkout), 1);
    chk("stop_high_busy", int'(busy), 1);
    step();
    chk("stop_bound_clkout", int'(clkout), 0);
    chk("stop_bound_busy", int'(busy), 0);
    run_to(40);
    chk("stop_no_more_rises", rise_n, 1);
    $display("[TB] stop-in-high fall=%0d rises=%0d", fall_at(0), rise_n);

    // Stop then start again during DRAIN: no gap.
    kick(0);
    busy_low = 0;
    while (e_idx < 45) begin
      stop  = (e_idx == 12);
      start = (e_idx == 15);
      step();
      if (!busy) busy_low++;
    end
    stop  = 1'b0;
    start = 1'b0;
    chk("restart_busy_low", busy_low, 0);
    chk("restart_fall1", fall_at(0), 20);
    chk("restart_rise2", rise_at(1), 30);
    chk("restart_fall2", fall_at(1), 40);
    chk("restart_tick_align", tick_bad, 0);
    $display("[TB] drain-restart falls=%0d,%0d rise2=%0d", fall_at(0), fall_at(1), rise_at(1));
    finish_run("restart");

    // Asynchronous reset at cnt=200 with a config pending.
    kick(163);
    run_to(100);
    offer(50);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("rst_pending_ready_low", int'(cfg_if.cfg_ready), 0);
    run_to(200);
    chk("rst_pre_clkout", int'(clkout), 1);
    #3;
    rst = 1'b1;
    #2;
    chk("rst_async_clkout", int'(clkout), 0);
    chk("rst_async_tick", int'(tick), 0);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_ready", int'(cfg_if.cfg_ready), 1);
    #4;
    rst = 1'b0;
    step();
    kick(0);
    run_to(490);
    chk("rst_after_rise1", rise_at(0), 163);
    chk("rst_after_fall1", fall_at(0), 326);
    chk("rst_after_rise2", rise_at(1), 489);
    $display("[TB] after-reset rise1=%0d fall1=%0d rise2=%0d", rise_at(0), fall_at(0), rise_at(1));
    finish_run("rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
